// File: rtl/control_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : control_fsm                                                      |
// | Brief   : Moore control sequencer (fetch/decode/execute) with memory-wait  |
// |           timeout. Optional JSR/JSRR support enabled by CTRL_JSR_EN.       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module control_fsm #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        i_CLK,
    input  logic        i_Reset,
    input  logic [15:0] i_IR,
    input  logic        i_N,
    input  logic        i_Z,
    input  logic        i_P,
    input  logic        i_MEM_R,
    output logic        o_LD_MAR,
    output logic        o_LD_MDR,
    output logic        o_LD_IR,
    output logic        o_LD_PC,
    output logic        o_LD_REG,
    output logic        o_LD_CC,
    output logic        o_GatePC,
    output logic        o_GateMDR,
    output logic        o_GateALU,
    output logic        o_GateMARMUX,
    output logic [1:0]  o_ALUK,
    output logic [1:0]  o_SR1MUX,
    output logic [1:0]  o_DRMUX,
    output logic [1:0]  o_PCMUX,
    output logic [1:0]  o_ADDR2MUX,
    output logic        o_ADDR1MUX,
    output logic        o_MARMUX,
    output logic        o_MIO_EN,
    output logic        o_R_W,
    output logic [5:0]  o_State,
    output logic        o_Error
);

    localparam logic [5:0] c_S0  = 6'd0,  c_S1  = 6'd1,  c_S2  = 6'd2,  c_S3  = 6'd3;
    localparam logic [5:0] c_S4  = 6'd4,  c_S5  = 6'd5,  c_S6  = 6'd6,  c_S7  = 6'd7;
    localparam logic [5:0] c_S9  = 6'd9,  c_S12 = 6'd12, c_S14 = 6'd14, c_S16 = 6'd16;
    localparam logic [5:0] c_S18 = 6'd18, c_S20 = 6'd20, c_S21 = 6'd21, c_S22 = 6'd22;
    localparam logic [5:0] c_S23 = 6'd23, c_S25 = 6'd25, c_S27 = 6'd27, c_S32 = 6'd32;
    localparam logic [5:0] c_S33 = 6'd33, c_S35 = 6'd35, c_S62 = 6'd62, c_S63 = 6'd63;

    localparam logic [7:0] c_TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [5:0] r_state;
    logic [5:0] w_next_state;
    logic [7:0] r_count;
    logic       w_ben;
    logic       w_timeout;
    logic       w_mem_state;
    logic       w_unused_ir;

    assign w_ben       = (i_IR[11] & i_N) | (i_IR[10] & i_Z) | (i_IR[9] & i_P);
    assign w_timeout   = (r_count == c_TIMEOUT_LAST);
    assign w_mem_state = (r_state == c_S33) || (r_state == c_S25) || (r_state == c_S16);
    assign w_unused_ir = ^i_IR[8:0];

    // Wait counter restarts whenever a memory state is entered or left.
    always_ff @(posedge i_CLK or negedge i_Reset) begin
        if (!i_Reset) begin
            r_state <= c_S62;
            r_count <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_count <= (w_mem_state && (w_next_state == r_state)) ? r_count + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S62: w_next_state = c_S18;
            c_S18: w_next_state = c_S33;
            c_S33: begin
                if (i_MEM_R)        w_next_state = c_S35;
                else if (w_timeout) w_next_state = c_S63;
            end
            c_S35: w_next_state = c_S32;
            c_S32: begin
                case (i_IR[15:12])
                    4'b0001: w_next_state = c_S1;
                    4'b0101: w_next_state = c_S5;
                    4'b1001: w_next_state = c_S9;
                    4'b0000: w_next_state = c_S0;
                    4'b1100: w_next_state = c_S12;
                    4'b1110: w_next_state = c_S14;
                    4'b0010: w_next_state = c_S2;
                    4'b0110: w_next_state = c_S6;
                    4'b0011: w_next_state = c_S3;
                    4'b0111: w_next_state = c_S7;
`ifdef CTRL_JSR_EN
                    4'b0100: w_next_state = c_S4;
`endif
                    default: w_next_state = c_S63;
                endcase
            end
            c_S0:  w_next_state = w_ben ? c_S22 : c_S18;
            c_S1, c_S5, c_S9, c_S12, c_S14, c_S22, c_S27: w_next_state = c_S18;
            c_S2, c_S6: w_next_state = c_S25;
            c_S3, c_S7: w_next_state = c_S23;
            c_S25: begin
                if (i_MEM_R)        w_next_state = c_S27;
                else if (w_timeout) w_next_state = c_S63;
            end
            c_S23: w_next_state = c_S16;
            c_S16: begin
                if (i_MEM_R)        w_next_state = c_S18;
                else if (w_timeout) w_next_state = c_S63;
            end
`ifdef CTRL_JSR_EN
            c_S4:  w_next_state = i_IR[11] ? c_S21 : c_S20;
            c_S20, c_S21: w_next_state = c_S18;
`endif
            c_S63: w_next_state = c_S63;
            default: w_next_state = c_S63;
        endcase
    end

    assign o_State = r_state;
    assign o_Error = (r_state == c_S63);

    always_comb begin
        o_LD_MAR     = 1'b0;
        o_LD_MDR     = 1'b0;
        o_LD_IR      = 1'b0;
        o_LD_PC      = 1'b0;
        o_LD_REG     = 1'b0;
        o_LD_CC      = 1'b0;
        o_GatePC     = 1'b0;
        o_GateMDR    = 1'b0;
        o_GateALU    = 1'b0;
        o_GateMARMUX = 1'b0;
        o_ALUK       = 2'b00;
        o_SR1MUX     = 2'b00;
        o_DRMUX      = 2'b00;
        o_PCMUX      = 2'b00;
        o_ADDR2MUX   = 2'b00;
        o_ADDR1MUX   = 1'b0;
        o_MARMUX     = 1'b0;
        o_MIO_EN     = 1'b0;
        o_R_W        = 1'b0;
        case (r_state)
            c_S18: begin
                o_LD_MAR = 1'b1; o_GatePC = 1'b1; o_LD_PC = 1'b1;
            end
            c_S33, c_S25: begin
                o_MIO_EN = 1'b1; o_LD_MDR = 1'b1;
            end
            c_S35: begin
                o_GateMDR = 1'b1; o_LD_IR = 1'b1;
            end
            c_S1, c_S5, c_S9: begin
                o_GateALU = 1'b1; o_LD_REG = 1'b1; o_LD_CC = 1'b1; o_SR1MUX = 2'b01;
                o_ALUK = (r_state == c_S1) ? 2'b00 : (r_state == c_S5) ? 2'b01 : 2'b10;
            end
            c_S22: begin
                o_LD_PC = 1'b1; o_PCMUX = 2'b10; o_ADDR2MUX = 2'b10;
            end
            c_S12: begin
                o_LD_PC = 1'b1; o_PCMUX = 2'b10; o_ADDR1MUX = 1'b1; o_SR1MUX = 2'b01;
            end
            c_S14: begin
                o_GateMARMUX = 1'b1; o_MARMUX = 1'b1; o_ADDR2MUX = 2'b10; o_LD_REG = 1'b1;
            end
            c_S2, c_S3: begin
                o_LD_MAR = 1'b1; o_GateMARMUX = 1'b1; o_MARMUX = 1'b1; o_ADDR2MUX = 2'b10;
            end
            c_S6, c_S7: begin
                o_LD_MAR = 1'b1; o_GateMARMUX = 1'b1; o_MARMUX = 1'b1;
                o_ADDR1MUX = 1'b1; o_SR1MUX = 2'b01; o_ADDR2MUX = 2'b01;
            end
            c_S27: begin
                o_GateMDR = 1'b1; o_LD_REG = 1'b1; o_LD_CC = 1'b1;
            end
            c_S23: begin
                o_GateALU = 1'b1; o_ALUK = 2'b11; o_LD_MDR = 1'b1;
            end
            c_S16: begin
                o_MIO_EN = 1'b1; o_R_W = 1'b1;
            end
`ifdef CTRL_JSR_EN
            c_S21: begin
                o_GatePC = 1'b1; o_LD_REG = 1'b1; o_DRMUX = 2'b10;
                o_LD_PC = 1'b1; o_PCMUX = 2'b10; o_ADDR2MUX = 2'b11;
            end
            c_S20: begin
                o_GatePC = 1'b1; o_LD_REG = 1'b1; o_DRMUX = 2'b10; o_LD_PC = 1'b1;
                o_PCMUX = 2'b10; o_ADDR1MUX = 1'b1; o_SR1MUX = 2'b01;
            end
`endif
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum cycles any single memory access waits for i_MEM_R before faulting (range 1-255).
REQ-002 SHALL have port i_CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port i_Reset  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port i_IR  input  16  current instruction register contents; [15:12] opcode.
REQ-005 SHALL have ports i_N, i_Z, i_P  input  1 each  current condition codes.
REQ-006 SHALL have port i_MEM_R  input  1  memory ready; one-cycle pulse completes the access.
REQ-007 SHALL have ports o_LD_MAR, o_LD_MDR, o_LD_IR, o_LD_PC, o_LD_REG, o_LD_CC  output  1 each  register load enables.
REQ-008 SHALL have ports o_GatePC, o_GateMDR, o_GateALU, o_GateMARMUX  output  1 each  bus drivers, at most one high per cycle.
REQ-009 SHALL have ports o_ALUK, o_SR1MUX, o_DRMUX, o_PCMUX, o_ADDR2MUX  output  2 each; o_ADDR1MUX, o_MARMUX  output  1 each  datapath selects.
REQ-010 SHALL have ports o_MIO_EN  output  1  memory access request; o_R_W  output  1  1=write.
REQ-011 SHALL have ports o_State  output  6  current state number; o_Error  output  1  sticky fault flag.

Function
REQ-012 SHALL use encodings: ALUK 00 ADD, 01 AND, 10 NOT, 11 pass SR1; SR1MUX/DRMUX 00 IR[11:9], 01 IR[8:6] (SR1) / R6 (DR), 10 R7 (DR); PCMUX 00 PC+1, 01 bus, 10 adder; ADDR1MUX 0 PC, 1 SR1; ADDR2MUX 00 zero, 01 off6, 10 off9, 11 off11; MARMUX 1 adder.
REQ-013 SHALL be Moore: every output a pure function of state; unlisted outputs 0 in every state.
REQ-014 SHALL implement fetch: S18 (LD_MAR, GatePC, LD_PC, PCMUX 00) -> S33 (MIO_EN, LD_MDR; hold until i_MEM_R) -> S35 (GateMDR, LD_IR) -> S32.
REQ-015 SHALL decode in S32 (no outputs asserted) by opcode: 0001 S1, 0101 S5, 1001 S9, 0000 S0, 1100 S12, 1110 S14, 0010 S2, 0110 S6, 0011 S3, 0111 S7, 0100 per REQ-030, all others S63.
REQ-016 S1/S5/S9 SHALL assert GateALU, LD_REG, LD_CC, SR1MUX 01, DRMUX 00, ALUK 00/01/10 respectively, then go to S18.
REQ-017 S0 SHALL go to S22 when BEN=(IR[11]&N)|(IR[10]&Z)|(IR[9]&P) is 1, else S18; S22 SHALL assert LD_PC, PCMUX 10, ADDR1MUX 0, ADDR2MUX 10, then S18.
REQ-018 S12 SHALL assert LD_PC, PCMUX 10, ADDR1MUX 1, SR1MUX 01, ADDR2MUX 00, then S18.
REQ-019 S14 SHALL assert GateMARMUX, MARMUX 1, ADDR1MUX 0, ADDR2MUX 10, LD_REG, DRMUX 00, then S18 (no LD_CC).
REQ-020 S2/S3 SHALL assert LD_MAR, GateMARMUX, MARMUX 1, ADDR1MUX 0, ADDR2MUX 10; S6/S7 same with ADDR1MUX 1, SR1MUX 01, ADDR2MUX 01.
REQ-021 S2, S6 SHALL go to S25 (MIO_EN, LD_MDR; hold until i_MEM_R) -> S27 (GateMDR, LD_REG, LD_CC, DRMUX 00) -> S18.
REQ-022 S3, S7 SHALL go to S23 (GateALU, ALUK 11, SR1MUX 00, LD_MDR) -> S16 (MIO_EN, R_W=1; hold until i_MEM_R) -> S18.
REQ-023 SHALL keep o_MIO_EN and o_R_W constant for the full duration of a memory state; exit occurs on the edge where i_MEM_R=1.
REQ-024 SHALL count wait cycles in S33/S25/S16, clearing the 8-bit counter on every memory-state entry; if i_MEM_R is still 0 when count reaches MEM_TIMEOUT, go to S63.
REQ-025 i_MEM_R asserted outside S33/S25/S16 SHALL be ignored.
REQ-026 S63 SHALL assert o_Error, drive all other outputs 0, and remain until reset.

Reset
REQ-027 While i_Reset=0 the FSM SHALL hold state S62 (idle), all outputs 0 including o_Error, o_State=62, counter 0.
REQ-028 The first rising edge after i_Reset returns to 1 SHALL move S62 -> S18.
REQ-029 Reset asserted mid-access (any state) SHALL immediately force S62 and deassert o_MIO_EN asynchronously.

Configuration
REQ-030 With CTRL_JSR_EN defined, opcode 0100 SHALL go to S4: IR[11]=1 -> S21 (GatePC, LD_REG, DRMUX 10, LD_PC, PCMUX 10, ADDR1MUX 0, ADDR2MUX 11); IR[11]=0 -> S20 (GatePC, LD_REG, DRMUX 10, LD_PC, PCMUX 10, ADDR1MUX 1, SR1MUX 01, ADDR2MUX 00); both then S18; without it, 0100 SHALL go to S63.

Verification
REQ-031 Reset release, IR=0x1042 (ADD), i_MEM_R after 2 cycles -> states 62,18,33,33,33,35,32,1,18; S1 shows GateALU, LD_REG, LD_CC, ALUK 00.
REQ-032 BR IR=0x0403 with Z=1 -> S0 then S22 with PCMUX 10, ADDR2MUX 10; with Z=0, N=1 -> S0 then S18.
REQ-033 STR IR=0x7042 -> S7, S23 (ALUK 11, LD_MDR), S16 with MIO_EN=1, R_W=1 held until i_MEM_R pulse, then S18.
REQ-034 MEM_TIMEOUT=3, i_MEM_R never asserted in S33 -> S63 after 3 wait cycles, o_Error=1 sticky; i_Reset low clears to S62.
REQ-035 IR=0x4805: with CTRL_JSR_EN -> S4, S21, DRMUX 10, PCMUX 10; without -> S63, o_Error=1.
REQ-036 Opcode 1101 in S32 -> S63; i_MEM_R pulse while in S1 -> no effect on sequence.
